// File: rtl/request_dispatcher_4rd_pkg.sv
// dispatch_pkg: shared constants, FSM state type and slave-index helper
// for the 4-port request dispatcher.
package dispatch_pkg;

  localparam int NUM_SLAVES    = 4;
  localparam int SLV_IDX_WIDTH = 2;

  typedef enum logic {
    ST_IDLE,
    ST_ISSUE
  } state_e;

  // Slave index lives in the top SLV_IDX_WIDTH address bits.
  function automatic logic [SLV_IDX_WIDTH-1:0] slv_idx(
    input logic [63:0] addr,
    input int          aw
  );
    return addr[aw-1 -: SLV_IDX_WIDTH];
  endfunction

endpackage

// File: rtl/request_dispatcher_4rd_if.sv
// request_dispatcher_4rd_if: master request, 4 slave ports, tag FIFO push
// and response-retire strobe. slave = dispatcher view, master = driver view.
interface request_dispatcher_4rd_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int TAG_WIDTH  = 2
);
  logic                  req_i;
  logic                  req_we_i;
  logic [ADDR_WIDTH-1:0] req_addr_bi;
  logic [DATA_WIDTH-1:0] req_wdata_bi;
  logic                  req_ack_o;

  logic                  slv0_req_o;
  logic                  slv0_we_o;
  logic [ADDR_WIDTH-1:0] slv0_addr_bo;
  logic [DATA_WIDTH-1:0] slv0_wdata_bo;
  logic                  slv0_ack_i;

  logic                  slv1_req_o;
  logic                  slv1_we_o;
  logic [ADDR_WIDTH-1:0] slv1_addr_bo;
  logic [DATA_WIDTH-1:0] slv1_wdata_bo;
  logic                  slv1_ack_i;

  logic                  slv2_req_o;
  logic                  slv2_we_o;
  logic [ADDR_WIDTH-1:0] slv2_addr_bo;
  logic [DATA_WIDTH-1:0] slv2_wdata_bo;
  logic                  slv2_ack_i;

  logic                  slv3_req_o;
  logic                  slv3_we_o;
  logic [ADDR_WIDTH-1:0] slv3_addr_bo;
  logic [DATA_WIDTH-1:0] slv3_wdata_bo;
  logic                  slv3_ack_i;

  logic                  tag_fifo_full;
  logic                  tag_fifo_wrreq;
  logic [TAG_WIDTH-1:0]  tag_fifo_wdata;
  logic                  rsp_done_i;

  modport slave (
    input  req_i, req_we_i, req_addr_bi,
    input  req_wdata_bi,
    output req_ack_o,
    output slv0_req_o, slv0_we_o,
    output slv0_addr_bo, slv0_wdata_bo,
    input  slv0_ack_i,
    output slv1_req_o, slv1_we_o,
    output slv1_addr_bo, slv1_wdata_bo,
    input  slv1_ack_i,
    output slv2_req_o, slv2_we_o,
    output slv2_addr_bo, slv2_wdata_bo,
    input  slv2_ack_i,
    output slv3_req_o, slv3_we_o,
    output slv3_addr_bo, slv3_wdata_bo,
    input  slv3_ack_i,
    input  tag_fifo_full,
    output tag_fifo_wrreq, tag_fifo_wdata,
    input  rsp_done_i
  );

  modport master (
    output req_i, req_we_i, req_addr_bi,
    output req_wdata_bi,
    input  req_ack_o,
    input  slv0_req_o, slv0_we_o,
    input  slv0_addr_bo, slv0_wdata_bo,
    output slv0_ack_i,
    input  slv1_req_o, slv1_we_o,
    input  slv1_addr_bo, slv1_wdata_bo,
    output slv1_ack_i,
    input  slv2_req_o, slv2_we_o,
    input  slv2_addr_bo, slv2_wdata_bo,
    output slv2_ack_i,
    input  slv3_req_o, slv3_we_o,
    input  slv3_addr_bo, slv3_wdata_bo,
    output slv3_ack_i,
    output tag_fifo_full,
    input  tag_fifo_wrreq, tag_fifo_wdata,
    output rsp_done_i
  );

endinterface

// File: rtl/request_dispatcher_4rd.sv
// request_dispatcher_4rd: routes in-order master requests to 4 slaves and
// pushes read tags; ports clk_i, rst_i (async, active-low), bus (slave).
module request_dispatcher_4rd
  import dispatch_pkg::*;
#(
  parameter int ADDR_WIDTH      = 32,
  parameter int DATA_WIDTH      = 32,
  parameter int TAG_WIDTH       = SLV_IDX_WIDTH,
  parameter int MAX_OUTSTANDING = 4
) (
  input logic                    clk_i,
  input logic                    rst_i,
  request_dispatcher_4rd_if.slave bus
);

  localparam int CW = $clog2(MAX_OUTSTANDING) + 1;

  state_e                  state_q;
  logic                    we_q;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [DATA_WIDTH-1:0]   wdata_q;
  logic [SLV_IDX_WIDTH-1:0] idx_q;
  logic                    ack_q;
  logic [CW-1:0]           outstanding_q;

  logic                    capture;
  logic                    sel_ack;
  logic                    inc;
  logic                    dec;
  logic [NUM_SLAVES-1:0]   req_vec;

  // Writes bypass read credits; the full check at capture suffices
  // because nothing else writes the tag FIFO.
  always_comb begin
    capture = (state_q == ST_IDLE) && bus.req_i &&
              (bus.req_we_i ||
               (outstanding_q < CW'(MAX_OUTSTANDING) &&
                !bus.tag_fifo_full));
    inc = capture && !bus.req_we_i;
    dec = bus.rsp_done_i && (outstanding_q != '0);
  end

  always_comb begin
    sel_ack = 1'b0;
    req_vec = '0;
    unique case (idx_q)
      2'd0: sel_ack = bus.slv0_ack_i;
      2'd1: sel_ack = bus.slv1_ack_i;
      2'd2: sel_ack = bus.slv2_ack_i;
      2'd3: sel_ack = bus.slv3_ack_i;
      default: sel_ack = 1'b0;
    endcase
    if (state_q == ST_ISSUE) begin
      req_vec[idx_q] = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q       <= ST_IDLE;
      we_q          <= 1'b0;
      addr_q        <= '0;
      wdata_q       <= '0;
      idx_q         <= '0;
      ack_q         <= 1'b0;
      outstanding_q <= '0;
    end else begin
      ack_q <= capture;
      unique case (state_q)
        ST_IDLE: begin
          if (capture) begin
            state_q <= ST_ISSUE;
            we_q    <= bus.req_we_i;
            addr_q  <= bus.req_addr_bi;
            wdata_q <= bus.req_wdata_bi;
            idx_q   <= slv_idx(64'(bus.req_addr_bi),
                               ADDR_WIDTH);
          end
        end
        ST_ISSUE: begin
          if (sel_ack) begin
            state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
      // Simultaneous capture and retire cancel out.
      unique case ({inc, dec})
        2'b10: outstanding_q <= outstanding_q + CW'(1);
        2'b01: outstanding_q <= outstanding_q - CW'(1);
        default: outstanding_q <= outstanding_q;
      endcase
    end
  end

  assign bus.req_ack_o = ack_q;

  assign bus.slv0_req_o = req_vec[0];
  assign bus.slv1_req_o = req_vec[1];
  assign bus.slv2_req_o = req_vec[2];
  assign bus.slv3_req_o = req_vec[3];

  assign bus.slv0_we_o = we_q;
  assign bus.slv1_we_o = we_q;
  assign bus.slv2_we_o = we_q;
  assign bus.slv3_we_o = we_q;

  assign bus.slv0_addr_bo = addr_q;
  assign bus.slv1_addr_bo = addr_q;
  assign bus.slv2_addr_bo = addr_q;
  assign bus.slv3_addr_bo = addr_q;

  assign bus.slv0_wdata_bo = wdata_q;
  assign bus.slv1_wdata_bo = wdata_q;
  assign bus.slv2_wdata_bo = wdata_q;
  assign bus.slv3_wdata_bo = wdata_q;

  // Tag push coincides with the selected slave's accept of a read.
  assign bus.tag_fifo_wrreq =
    (state_q == ST_ISSUE) && sel_ack && !we_q;
  assign bus.tag_fifo_wdata = TAG_WIDTH'(idx_q);

endmodule

// File: tb/tb_request_dispatcher_4rd.sv
// tb_request_dispatcher_4rd: directed stimulus, transaction-level model,
// per-cycle compare plus literal spot checks.
module tb_request_dispatcher_4rd;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  request_dispatcher_4rd_if bus ();

  request_dispatcher_4rd dut (
    .clk_i (clk),
    .rst_i (rst_n),
    .bus   (bus)
  );

  int checks = 0;
  int fails  = 0;
  int pushes = 0;

  task automatic chk(string nm, logic [63:0] act,
                     logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h",
               nm, act, exp);
    end
  endtask

  // slave responder
  logic [3:0] sack;
  int   ack_dly = 0;
  bit   ack_block = 0;
  bit   stray = 0;
  int   stray_port = 0;
  int   wcnt[4];
  logic [3:0] rq;

  assign rq = {bus.slv3_req_o, bus.slv2_req_o,
               bus.slv1_req_o, bus.slv0_req_o};
  assign bus.slv0_ack_i = sack[0];
  assign bus.slv1_ack_i = sack[1];
  assign bus.slv2_ack_i = sack[2];
  assign bus.slv3_ack_i = sack[3];

  initial begin
    sack = '0;
    for (int n = 0; n < 4; n++) wcnt[n] = 0;
    forever begin
      @(posedge clk);
      #1;
      for (int n = 0; n < 4; n++) begin
        if (rq[n] && !ack_block) begin
          sack[n] = (wcnt[n] == ack_dly);
          wcnt[n]++;
        end else begin
          sack[n] = 1'b0;
          wcnt[n] = 0;
        end
      end
      if (stray) sack[stray_port] = 1'b1;
    end
  end

  // transaction model: one pending request, read credit count
  bit          m_busy;
  bit          m_ack;
  bit          m_we;
  logic [31:0] m_addr;
  logic [31:0] m_wdata;
  int          m_idx;
  int          m_out;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy  = 0;
      m_ack   = 0;
      m_we    = 0;
      m_addr  = '0;
      m_wdata = '0;
      m_idx   = 0;
      m_out   = 0;
    end else begin
      bit grant;
      int nxt;
      grant = !m_busy && bus.req_i &&
              (bus.req_we_i ||
               (m_out < 4 && !bus.tag_fifo_full));
      nxt = m_out;
      if (grant && !bus.req_we_i) nxt++;
      if (bus.rsp_done_i && m_out > 0) nxt--;
      if (m_busy && sack[m_idx]) m_busy = 0;
      if (grant) begin
        m_busy  = 1;
        m_we    = bus.req_we_i;
        m_addr  = bus.req_addr_bi;
        m_wdata = bus.req_wdata_bi;
        m_idx   = int'(bus.req_addr_bi[31:30]);
      end
      m_ack = grant;
      m_out = nxt;
    end
  end

  // per-cycle compare
  always @(negedge clk) begin
    logic [31:0] aa[4];
    logic [31:0] dd[4];
    logic        ww[4];
    logic [3:0]  exp_rq;
    bit          exp_push;
    aa = '{bus.slv0_addr_bo, bus.slv1_addr_bo,
           bus.slv2_addr_bo, bus.slv3_addr_bo};
    dd = '{bus.slv0_wdata_bo, bus.slv1_wdata_bo,
           bus.slv2_wdata_bo, bus.slv3_wdata_bo};
    ww = '{bus.slv0_we_o, bus.slv1_we_o,
           bus.slv2_we_o, bus.slv3_we_o};
    exp_rq = m_busy ? (4'b1 << m_idx) : 4'b0;
    exp_push = m_busy && !m_we && sack[m_idx];
    chk("req_ack", bus.req_ack_o, m_ack);
    chk("slv_req", rq, exp_rq);
    for (int n = 0; n < 4; n++) begin
      chk($sformatf("addr%0d", n), aa[n], m_addr);
      chk($sformatf("wdata%0d", n), dd[n], m_wdata);
      chk($sformatf("we%0d", n), ww[n], m_we);
    end
    chk("tag_wrreq", bus.tag_fifo_wrreq, exp_push);
    if (exp_push) begin
      chk("tag_wdata", bus.tag_fifo_wdata, m_idx);
    end
    if (bus.tag_fifo_wrreq === 1'b1) pushes++;
    chk("outstanding", dut.outstanding_q, m_out);
  end

  // driver helpers
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_req(input bit we,
                        input logic [31:0] a,
                        input logic [31:0] d,
                        input int limit,
                        output bit got);
    got = 0;
    bus.req_i        = 1'b1;
    bus.req_we_i     = we;
    bus.req_addr_bi  = a;
    bus.req_wdata_bi = d;
    for (int i = 0; i < limit; i++) begin
      tick();
      if (bus.req_ack_o === 1'b1) begin
        got = 1;
        break;
      end
    end
    if (got) bus.req_i = 1'b0;
  endtask

  task automatic finish_issue();
    bit done;
    done = 0;
    for (int k = 0; k < 12; k++) begin
      if (rq == 4'b0) begin
        done = 1;
        break;
      end
      tick();
    end
    chk("issue_timeout", done, 1);
  endtask

  task automatic rsp_pulse(input int n);
    bus.rsp_done_i = 1'b1;
    repeat (n) tick();
    bus.rsp_done_i = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit got;
    bus.req_i         = 1'b0;
    bus.req_we_i      = 1'b0;
    bus.req_addr_bi   = '0;
    bus.req_wdata_bi  = '0;
    bus.tag_fifo_full = 1'b0;
    bus.rsp_done_i    = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    tick();
    chk("rst_ack", bus.req_ack_o, 0);
    chk("rst_out", dut.outstanding_q, 0);

    // retire at zero credits is ignored
    rsp_pulse(1);
    chk("rsp_at_zero", dut.outstanding_q, 0);

    // 1: reset in the middle of an issue to slave 2
    ack_block = 1;
    do_req(0, 32'h8000_0000, 0, 4, got);
    chk("t1_got", got, 1);
    chk("t1_slv2", bus.slv2_req_o, 1);
    tick();
    chk("t1_out", dut.outstanding_q, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("t1_rst_slv2", bus.slv2_req_o, 0);
    chk("t1_rst_rq", rq, 0);
    chk("t1_rst_addr", bus.slv2_addr_bo, 0);
    chk("t1_rst_push", bus.tag_fifo_wrreq, 0);
    chk("t1_rst_ack", bus.req_ack_o, 0);
    ack_block = 0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    tick();
    chk("t1_out_after", dut.outstanding_q, 0);

    // 2: read to slave 3, same-cycle accept
    ack_dly = 0;
    do_req(0, 32'hC000_0010, 0, 4, got);
    chk("t2_got", got, 1);
    #1;
    chk("t2_slv3", bus.slv3_req_o, 1);
    chk("t2_push", bus.tag_fifo_wrreq, 1);
    chk("t2_tag", bus.tag_fifo_wdata, 3);
    tick();
    chk("t2_slv3_off", bus.slv3_req_o, 0);
    chk("t2_ack_pulse", bus.req_ack_o, 0);
    chk("t2_out", dut.outstanding_q, 1);
    rsp_pulse(1);

    // 3: five reads, the fifth waits for a retire
    do_req(0, 32'h0000_0100, 0, 4, got);
    chk("t3_got0", got, 1);
    finish_issue();
    do_req(0, 32'h4000_0104, 0, 4, got);
    chk("t3_got1", got, 1);
    finish_issue();
    do_req(0, 32'h8000_0108, 0, 4, got);
    chk("t3_got2", got, 1);
    finish_issue();
    do_req(0, 32'hC000_010C, 0, 4, got);
    chk("t3_got3", got, 1);
    finish_issue();
    chk("t3_out4", dut.outstanding_q, 4);
    do_req(0, 32'h0000_0110, 0, 6, got);
    chk("t3_held", got, 0);
    rsp_pulse(1);
    do_req(0, 32'h0000_0110, 0, 3, got);
    chk("t3_released", got, 1);
    finish_issue();
    chk("t3_out_end", dut.outstanding_q, 4);

    // 4: write passes with no credits and full FIFO
    bus.tag_fifo_full = 1'b1;
    stray = 1;
    stray_port = 0;
    ack_dly = 2;
    do_req(1, 32'h4000_0020, 32'hDEAD_BEEF, 3, got);
    chk("t4_got", got, 1);
    #1;
    chk("t4_slv1", bus.slv1_req_o, 1);
    chk("t4_slv0", bus.slv0_req_o, 0);
    chk("t4_we", bus.slv1_we_o, 1);
    chk("t4_bcast", bus.slv0_wdata_bo, 32'hDEAD_BEEF);
    finish_issue();
    stray = 0;
    ack_dly = 0;
    chk("t4_pushes", pushes, 6);
    chk("t4_out", dut.outstanding_q, 4);

    // 5: read stalls on full, captured once it drops
    rsp_pulse(2);
    do_req(0, 32'h8000_0030, 0, 3, got);
    chk("t5_stall", got, 0);
    bus.tag_fifo_full = 1'b0;
    do_req(0, 32'h8000_0030, 0, 1, got);
    chk("t5_next", got, 1);
    finish_issue();
    chk("t5_out", dut.outstanding_q, 3);

    // 6: capture and retire on the same edge
    rsp_pulse(1);
    chk("t6_out_pre", dut.outstanding_q, 2);
    bus.req_i        = 1'b1;
    bus.req_we_i     = 1'b0;
    bus.req_addr_bi  = 32'h0000_0040;
    bus.rsp_done_i   = 1'b1;
    tick();
    bus.rsp_done_i   = 1'b0;
    bus.req_i        = 1'b0;
    chk("t6_ack", bus.req_ack_o, 1);
    chk("t6_out", dut.outstanding_q, 2);
    finish_issue();
    chk("t6_out_end", dut.outstanding_q, 2);
    tick();
    chk("total_pushes", pushes, 8);

    $display("End of test - %0d assertions evaluated, %0d failures",
             checks, fails);
    $finish;
  end

endmodule
